instr_fetch_queue: RTL and testbench

Instruction-fetch front end and reader of the program-counter stream. It owns the fetch PC and issues sequential word-aligned read requests to instruction memory over a valid/ready request channel. It accepts in-order responses, pairs each response with its request address, and buffers {pc, instr} pairs for the decode stage behind a valid/ready output. A redirect input (branch/jump target) reloads the fetch PC, flushes buffered entries and discards in-flight responses.

---
 rtl/instr_fetch_queue.sv | 115 +++++++++++
 tb/tb_instr_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word reads,
// pairs each response with its request PC and buffers {pc, instr} for decode.
module instr_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_req_ready,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   input  logic                  out_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic                  run;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [CW-1:0]         pending, drop_cnt, out_count;
   logic [PW-1:0]         pc_wr, pc_rd, o_wr, o_rd;
   logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
   logic [ADDR_WIDTH-1:0] opc_mem [DEPTH];
   logic [DATA_WIDTH-1:0] oin_mem [DEPTH];

   logic [CW:0] credit_sum;
   logic        acc, rsp_ok, rsp_keep, pop;

   // run holds off requests until the first edge after reset release
   always_comb begin
      credit_sum     = {1'b0, pending} + {1'b0, out_count};
      imem_req_valid = run && !redirect_valid && (credit_sum < DEPTH_W);
      imem_req_addr  = fetch_pc;
      acc            = imem_req_valid && imem_req_ready;
      rsp_ok         = imem_rsp_valid && (pending != '0);
      rsp_keep       = rsp_ok && (drop_cnt == '0) && !redirect_valid;
      out_valid      = (out_count != '0);
      pop            = out_valid && out_ready && !redirect_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run       <= 1'b0;
         fetch_pc  <= RESET_PC;
         pending   <= '0;
         drop_cnt  <= '0;
         out_count <= '0;
         pc_wr     <= '0;
         pc_rd     <= '0;
         o_wr      <= '0;
         o_rd      <= '0;
         out_pc    <= '0;
         out_instr <= '0;
      end else begin
         run <= 1'b1;
         if (redirect_valid) begin
            // everything still in flight belongs to the old path and is dropped
            fetch_pc  <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            pc_rd     <= pc_wr;
            o_rd      <= o_wr;
            out_count <= '0;
            pending   <= pending - CW'(rsp_ok);
            drop_cnt  <= pending - CW'(rsp_ok);
         end else begin
            if (acc) begin
               pc_wr    <= pc_wr + PW'(1);
               fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            pending <= pending + CW'(acc) - CW'(rsp_ok);
            if (rsp_ok && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CW'(1);
            if (rsp_keep) begin
               pc_rd <= pc_rd + PW'(1);
               o_wr  <= o_wr + PW'(1);
            end
            if (pop)
               o_rd <= o_rd + PW'(1);
            out_count <= out_count + CW'(rsp_keep) - CW'(pop);
            // head registers: advance on pop, load on push into empty, else hold
            if (pop) begin
               if (out_count > CW'(1)) begin
                  out_pc    <= opc_mem[o_rd + PW'(1)];
                  out_instr <= oin_mem[o_rd + PW'(1)];
               end else if (rsp_keep) begin
                  out_pc    <= pc_mem[pc_rd];
                  out_instr <= imem_rsp_data;
               end
            end else if ((out_count == '0) && rsp_keep) begin
               out_pc    <= pc_mem[pc_rd];
               out_instr <= imem_rsp_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc)
         pc_mem[pc_wr] <= fetch_pc;
      if (rsp_keep) begin
         opc_mem[o_wr] <= pc_mem[pc_rd];
         oin_mem[o_wr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: in-order memory model with variable
// latency, random redirects and backpressure; expected pairs queued at accept.
module tb_instr_fetch_queue;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          imem_req_valid;
   logic [AW-1:0] imem_req_addr;
   logic          imem_req_ready;
   logic          imem_rsp_valid;
   logic [DW-1:0] imem_rsp_data;
   logic          out_valid;
   logic [AW-1:0] out_pc;
   logic [DW-1:0] out_instr;
   logic          out_ready;

   always #5 clk = ~clk;

   instr_fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_ready(out_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [AW-1:0] mpc;
   logic [63:0]   exp_q[$];
   logic [AW-1:0] mq_addr[$];
   int            mq_due[$];
   int            cyc, lat, acc_cnt, pop_cnt, first_acc_cyc, first_out_cyc;
   bit            rnd_ready, rnd_out, rnd_rsp, rnd_lat, r_fix, o_fix;
   bit            prev_stall;
   logic [AW-1:0] prev_addr;

   function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // one cycle: drive at negedge, settle, check/model, advance to next negedge
   task automatic step(input bit redir, input logic [AW-1:0] rpc);
      logic [63:0] e;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = rnd_ready ? 1'($urandom % 2) : r_fix;
      out_ready      = rnd_out ? 1'($urandom % 4 != 0) : o_fix;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc && (!rnd_rsp || ($urandom % 2 == 1))) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      if (prev_stall && !redir) begin
         chk("hold_valid", 64'(imem_req_valid), 64'd1);
         chk("hold_addr", 64'(imem_req_addr), 64'(prev_addr));
      end
      if (redir) chk("req_on_redirect", 64'(imem_req_valid), 64'd0);
      if (out_valid && out_ready && !redir) begin
         if (first_out_cyc < 0) first_out_cyc = cyc;
         pop_cnt++;
         if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("out_pc", 64'(out_pc), 64'(e[63:32]));
            chk("out_instr", 64'(out_instr), 64'(e[31:0]));
         end
      end
      if (redir) begin
         exp_q.delete();
         mpc = {rpc[AW-1:2], 2'b00};
      end
      if (imem_req_valid && imem_req_ready) begin
         chk("req_addr", 64'(imem_req_addr), 64'(mpc));
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
         acc_cnt++;
         exp_q.push_back({mpc, instr_of(mpc)});
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + (rnd_lat ? int'($urandom_range(3, 1)) : lat));
         chk("outstanding_bound", 64'(mq_addr.size() <= D), 64'd1);
         mpc = mpc + 32'd4;
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete(); mq_addr.delete(); mq_due.delete();
      mpc = 32'h0; prev_stall = 1'b0; prev_addr = '0;
      cyc = 0; acc_cnt = 0; pop_cnt = 0; first_acc_cyc = -1; first_out_cyc = -1;
      rnd_ready = 0; rnd_out = 0; rnd_rsp = 0; rnd_lat = 0;
      r_fix = 1; o_fix = 1; lat = 1;
   endtask

   int p0, a0;

   initial begin
      rst = 1'b1;
      // streaming: first entry two cycles after first accept, then one per cycle
      do_reset();
      repeat (10) step(0, '0);
      chk("first_out_latency", 64'(first_out_cyc - first_acc_cyc), 64'd2);
      p0 = pop_cnt; a0 = acc_cnt;
      repeat (20) step(0, '0);
      chk("tput_pop", 64'(pop_cnt - p0), 64'd20);
      chk("tput_acc", 64'(acc_cnt - a0), 64'd20);

      // decode stalled: credits cap requests at DEPTH
      do_reset();
      o_fix = 0;
      repeat (10) step(0, '0);
      chk("credit_acc", 64'(acc_cnt), 64'd4);
      chk("credit_stop", 64'(imem_req_valid), 64'd0);
      o_fix = 1;
      repeat (12) step(0, '0);
      chk("credit_resume", 64'(acc_cnt >= 8), 64'd1);

      // memory not ready: address held, accepted on 4th cycle of valid
      do_reset();
      r_fix = 0;
      repeat (4) step(0, '0);
      r_fix = 1;
      repeat (8) step(0, '0);
      chk("stall_first_acc", 64'(first_acc_cyc), 64'd4);

      // redirect with requests in flight and entries buffered
      do_reset();
      lat = 3;
      repeat (5) step(0, '0);
      o_fix = 0;
      step(0, '0);
      step(1, 32'h0000_0103);
      o_fix = 1;
      repeat (14) step(0, '0);
      // redirect near the top of the address space: PC wraps to zero
      step(1, 32'hFFFF_FFF9);
      repeat (12) step(0, '0);

      // random stress: backpressure, latency, back-to-back redirects
      rnd_ready = 1; rnd_out = 1; rnd_rsp = 1; rnd_lat = 1;
      for (int i = 0; i < 600; i++)
         step(($urandom % 12) == 0, $urandom);

      // drain with requests blocked: everything accepted must come out
      rnd_ready = 0; rnd_out = 0; rnd_rsp = 0; rnd_lat = 0;
      r_fix = 0; o_fix = 1;
      repeat (16) step(0, '0);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      do_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
